// File: rtl/lfsr_seq_gen.sv
// Serial test-stream transmitter: GAP LFSR filler bits, then a fixed pattern, repeated
// until stopped. Feeds the LFSR sequence detector and counts the patterns sent.
module lfsr_seq_gen #(
  parameter int unsigned          LFSR_W  = 8,
  parameter logic [LFSR_W-1:0]    SEED    = 8'hA5,
  parameter logic [LFSR_W-1:0]    TAPS    = 8'hB8,
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter int unsigned          GAP     = 16,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             pat_start,
  output logic             busy,
  output logic [CNT_W-1:0] pat_count
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_lat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      stop_lat  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      pat_start <= 1'b0;
      busy      <= 1'b0;
      pat_count <= '0;
    end else begin
      bit_valid <= 1'b0;
      pat_start <= 1'b0;
      case (state)
        IDLE: begin
          bit_out  <= 1'b0;
          stop_lat <= 1'b0;
          if (start && !stop) begin
            state   <= FILL;
            gap_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          // stop abandons the filler immediately; the pending bit is dropped
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_out <= 1'b0;
          end else if (tick_en) begin
            bit_out   <= lfsr[LFSR_W-1];
            bit_valid <= 1'b1;
            if (lfsr == '0)
              lfsr <= SEED;
            else
              lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
            gap_cnt <= gap_cnt + GAP_W'(1);
            if (gap_cnt == GAP_W'(GAP - 1)) begin
              state   <= SEND;
              bit_idx <= IDX_W'(PAT_W - 1);
            end
          end
        end
        SEND: begin
          if (stop)
            stop_lat <= 1'b1;
          if (tick_en) begin
            bit_out   <= PATTERN[bit_idx];
            bit_valid <= 1'b1;
            pat_start <= (bit_idx == IDX_W'(PAT_W - 1));
            if (bit_idx == '0) begin
              pat_count <= pat_count + CNT_W'(1);
              // a stop arriving on the final bit counts the same as a latched one
              if (stop_lat || stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                stop_lat <= 1'b0;
              end else begin
                state   <= FILL;
                gap_cnt <= '0;
              end
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
